// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: widths, opcodes, ALU function codes,
// FSM state encodings and flag bit positions.
package alu_op_sequencer_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned FLAG_W = 4;

  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  localparam logic [2:0] FS_ADD  = 3'b000;
  localparam logic [2:0] FS_SUB  = 3'b001;
  localparam logic [2:0] FS_AND  = 3'b010;
  localparam logic [2:0] FS_OR   = 3'b011;
  localparam logic [2:0] FS_XOR  = 3'b100;
  localparam logic [2:0] FS_SHL  = 3'b101;
  localparam logic [2:0] FS_SHR  = 3'b110;
  localparam logic [2:0] FS_PASB = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Flag vector layout is {C,V,N,Z}
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response channels plus status for the ALU op sequencer.
interface alu_op_sequencer_if;
  import alu_op_sequencer_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [3:0]          cmd_op;
  logic [DATA_W-1:0]   cmd_a;
  logic [DATA_W-1:0]   cmd_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RES_W-1:0]    rsp_y;
  logic [FLAG_W-1:0]   rsp_flags;
  logic                rsp_err;
  logic [FLAG_W-1:0]   flags;
  logic                busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_y, rsp_flags, rsp_err, flags, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_y, rsp_flags, rsp_err, flags, busy
  );

endinterface

// File: rtl/alu_op_sequencer_alu.sv
// 4-bit combinational ALU datapath; carry on SUB means "no borrow".
module alu_op_sequencer_alu
  import alu_op_sequencer_pkg::*;
(
  input  logic [2:0]        i_fs,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_y_c,
  output logic              o_c_c,
  output logic              o_v_c
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum = '0;
    o_y_c = '0;
    o_c_c = 1'b0;
    o_v_c = 1'b0;
    case (i_fs)
      FS_ADD: begin
        w_sum = {1'b0, i_a} + {1'b0, i_b};
        o_y_c = w_sum[DATA_W-1:0];
        o_c_c = w_sum[DATA_W];
        o_v_c = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
      end
      FS_SUB: begin
        w_sum = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;
        o_y_c = w_sum[DATA_W-1:0];
        o_c_c = w_sum[DATA_W];
        o_v_c = (i_a[3] != i_b[3]) && (w_sum[3] != i_a[3]);
      end
      FS_AND:  o_y_c = i_a & i_b;
      FS_OR:   o_y_c = i_a | i_b;
      FS_XOR:  o_y_c = i_a ^ i_b;
      FS_SHL: begin
        o_y_c = {i_a[2:0], 1'b0};
        o_c_c = i_a[3];
      end
      FS_SHR: begin
        o_y_c = {1'b0, i_a[3:1]};
        o_c_c = i_a[0];
      end
      default: o_y_c = i_b;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-driven controller around the 4-bit ALU: single-cycle ops, CMP, and a
// 4-step shift-add unsigned multiply, with a persistent flag register.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
)(
  input  logic                clk,
  input  logic                rst_n,
  alu_op_sequencer_if.slave   bus
);

  logic [1:0]        r_state, w_next_state;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a, r_b, r_p, r_q;
  logic [1:0]        r_cnt;
  logic              r_rsp_valid, r_rsp_err;
  logic [RES_W-1:0]  r_rsp_y;
  logic [FLAG_W-1:0] r_rsp_flags, r_flags;

  logic [2:0]        w_fs;
  logic [DATA_W-1:0] w_alu_a, w_alu_b, w_alu_y, w_p_nxt, w_q_nxt;
  logic              w_alu_c, w_alu_v, w_is_mul_cmd, w_illegal;
  logic [RES_W-1:0]  w_product;
  logic [FLAG_W-1:0] w_exec_flags, w_mul_flags;

  assign w_is_mul_cmd = MUL_EN && (bus.cmd_op == OP_MUL);
  // In EXEC an opcode of 8 can only mean MUL is disabled
  assign w_illegal    = (r_op > OP_CMP) || (r_op == OP_MUL);

  // ALU operand steering: always from internal registers
  always_comb begin
    w_fs    = r_op[2:0];
    w_alu_a = r_a;
    w_alu_b = r_b;
    if (r_state == ST_MUL) begin
      w_fs    = FS_ADD;
      w_alu_a = r_p;
      w_alu_b = r_q[0] ? r_a : '0;
    end else if (r_op == OP_CMP) begin
      w_fs    = FS_SUB;
    end
  end

  alu_op_sequencer_alu u_alu (
    .i_fs  (w_fs),
    .i_a   (w_alu_a),
    .i_b   (w_alu_b),
    .o_y_c (w_alu_y),
    .o_c_c (w_alu_c),
    .o_v_c (w_alu_v)
  );

  // One multiply step: right shift of {C,P,Q} with the adder carry entering the MSB
  assign w_p_nxt   = {w_alu_c, w_alu_y[3:1]};
  assign w_q_nxt   = {w_alu_y[0], r_q[3:1]};
  assign w_product = {w_p_nxt, w_q_nxt};

  always_comb begin
    w_exec_flags         = '0;
    w_exec_flags[FLAG_C] = w_alu_c;
    w_exec_flags[FLAG_V] = w_alu_v;
    w_exec_flags[FLAG_N] = w_alu_y[3];
    w_exec_flags[FLAG_Z] = (w_alu_y == '0);
    w_mul_flags          = '0;
    w_mul_flags[FLAG_N]  = w_product[7];
    w_mul_flags[FLAG_Z]  = (w_product == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.cmd_valid) w_next_state = w_is_mul_cmd ? ST_MUL : ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_MUL:  if (r_cnt == 2'd3) w_next_state = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.cmd_valid) begin
          r_op  <= bus.cmd_op;
          r_a   <= bus.cmd_a;
          r_b   <= bus.cmd_b;
          r_p   <= '0;
          r_q   <= bus.cmd_b;
          r_cnt <= '0;
        end
        ST_EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_illegal;
          if (w_illegal) begin
            r_rsp_y     <= '0;
            r_rsp_flags <= '0;
          end else begin
            r_rsp_y     <= (r_op == OP_CMP) ? '0 : {4'h0, w_alu_y};
            r_rsp_flags <= w_exec_flags;
            r_flags     <= w_exec_flags;
          end
        end
        ST_MUL: begin
          r_p   <= w_p_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_y     <= w_product;
            r_rsp_flags <= w_mul_flags;
            r_flags     <= w_mul_flags;
          end
        end
        default: if (bus.rsp_ready) r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_flags = r_rsp_flags;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases, random ops against an
// arithmetic reference model, backpressure, mid-multiply reset, and MUL disabled.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [3:0] mflags;

  alu_op_sequencer_if if_m ();
  alu_op_sequencer_if if_n ();

  alu_op_sequencer #(.MUL_EN(1'b1)) dut    (.clk(clk), .rst_n(rst_n), .bus(if_m));
  alu_op_sequencer #(.MUL_EN(1'b0)) dut_nm (.clk(clk), .rst_n(rst_n), .bus(if_n));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation's meaning
  function automatic void model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                output logic [7:0] y, output logic [3:0] fl,
                                output logic err, output int lat);
    int ia, ib, sa, sb, r, sr, p;
    logic [3:0] y4;
    logic c, v;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    c = 1'b0; v = 1'b0; r = 0; sr = 0;
    err = 1'b0; lat = 1; y = 8'h00; fl = 4'h0;
    case (op)
      4'd0:       begin r = ia + ib; c = (r > 15); sr = sa + sb; v = (sr > 7) || (sr < -8); end
      4'd1, 4'd9: begin r = ia - ib; c = (ia >= ib); sr = sa - sb; v = (sr > 7) || (sr < -8); end
      4'd2:       r = int'(a & b);
      4'd3:       r = int'(a | b);
      4'd4:       r = int'(a ^ b);
      4'd5:       begin r = ia * 2; c = (ia >= 8); end
      4'd6:       begin r = ia / 2; c = (ia % 2 == 1); end
      4'd7:       r = ib;
      default:    r = 0;
    endcase
    y4 = r[3:0];
    if (op == 4'd8) begin
      p   = ia * ib;
      y   = p[7:0];
      fl  = {1'b0, 1'b0, p >= 128, p == 0};
      lat = 4;
    end else if (op >= 4'd10) begin
      err = 1'b1;
    end else begin
      y  = (op == 4'd9) ? 8'h00 : {4'h0, y4};
      fl = {c, v, y4 >= 4'd8, y4 == 4'd0};
    end
  endfunction

  // Called just after a falling edge with the DUT idle; returns just after a falling edge.
  task automatic do_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input bit hold);
    logic [7:0] ey; logic [3:0] ef; logic ee; int el; int lat;
    model(op, a, b, ey, ef, ee, el);
    check("cmd_ready_idle", if_m.cmd_ready, 1);
    if_m.rsp_ready = !hold;
    if_m.cmd_valid = 1'b1;
    if_m.cmd_op = op; if_m.cmd_a = a; if_m.cmd_b = b;
    @(negedge clk);
    // Garbage command held while busy must be ignored
    if_m.cmd_op = 4'($urandom); if_m.cmd_a = 4'($urandom); if_m.cmd_b = 4'($urandom);
    lat = 0;
    while (!if_m.rsp_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, el);
    check("rsp_y", if_m.rsp_y, ey);
    check("rsp_flags", if_m.rsp_flags, ef);
    check("rsp_err", if_m.rsp_err, ee);
    if (!ee) mflags = ef;
    check("flags_reg", if_m.flags, mflags);
    check("busy_resp", if_m.busy, 1);
    check("cmd_ready_busy", if_m.cmd_ready, 0);
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("bp_valid", if_m.rsp_valid, 1);
        check("bp_y", if_m.rsp_y, ey);
        check("bp_flags", if_m.rsp_flags, ef);
        check("bp_cmd_ready", if_m.cmd_ready, 0);
      end
      if_m.rsp_ready = 1'b1;
    end
    @(negedge clk);
    if_m.cmd_valid = 1'b0;
    check("rsp_valid_drop", if_m.rsp_valid, 0);
    check("busy_idle", if_m.busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    mflags = 4'h0;
    if_m.cmd_valid = 1'b0; if_m.cmd_op = '0; if_m.cmd_a = '0; if_m.cmd_b = '0; if_m.rsp_ready = 1'b1;
    if_n.cmd_valid = 1'b0; if_n.cmd_op = '0; if_n.cmd_a = '0; if_n.cmd_b = '0; if_n.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", if_m.rsp_valid, 0);
    check("rst_rsp_y", if_m.rsp_y, 0);
    check("rst_flags", if_m.flags, 0);
    check("rst_busy", if_m.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL disabled: opcode 8 is illegal with EXEC latency
    if_n.cmd_valid = 1'b1; if_n.cmd_op = 4'd8; if_n.cmd_a = 4'd3; if_n.cmd_b = 4'd5;
    @(negedge clk);
    if_n.cmd_valid = 1'b0;
    @(negedge clk);
    check("nm_valid", if_n.rsp_valid, 1);
    check("nm_err", if_n.rsp_err, 1);
    check("nm_y", if_n.rsp_y, 0);
    check("nm_flags", if_n.flags, 0);
    @(negedge clk);

    do_op(4'd0, 4'd7, 4'd1, 1'b0);
    do_op(4'd1, 4'd3, 4'd3, 1'b0);
    do_op(4'd9, 4'd2, 4'd5, 1'b0);
    do_op(4'd8, 4'd15, 4'd15, 1'b0);
    do_op(4'd8, 4'd0, 4'd9, 1'b0);
    do_op(4'd0, 4'd9, 4'd9, 1'b0);
    do_op(4'hC, 4'd4, 4'd4, 1'b0);
    do_op(4'd0, 4'd5, 4'd6, 1'b1);
    do_op(4'd2, 4'd12, 4'd10, 1'b0);

    for (int i = 0; i < 60; i++)
      do_op(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 1'b0);

    // Reset in the middle of a multiply
    do_op(4'd0, 4'd7, 4'd1, 1'b0);
    if_m.cmd_valid = 1'b1; if_m.cmd_op = 4'd8; if_m.cmd_a = 4'd13; if_m.cmd_b = 4'd11;
    @(negedge clk);
    if_m.cmd_valid = 1'b0;
    @(negedge clk);
    check("mul_busy", if_m.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", if_m.busy, 0);
    repeat (2) @(negedge clk);
    check("midrst_valid", if_m.rsp_valid, 0);
    check("midrst_flags", if_m.flags, 0);
    rst_n = 1'b1;
    mflags = 4'h0;
    @(negedge clk);
    check("midrst_cmd_ready", if_m.cmd_ready, 1);
    do_op(4'd8, 4'd13, 4'd11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
